// File: rtl/normmult_nch_if.sv
// normmult_nch_if -- sample, coefficient and result bundle for normmult_nch.
//
// Parameters mirror the block: WIDTH (signed sample width), CWIDTH (unsigned
// coefficient width), NCH (channel count, CHW = max(1, clog2(NCH))).
//
// Signals (master = sample/coefficient source, slave = normmult_nch):
//   din        WIDTH  signed input sample
//   din_valid  1      sample strobe
//   din_ch     CHW    channel of the sample
//   coef_we    1      coefficient write strobe
//   coef_addr  CHW    coefficient channel index
//   coef_data  CWIDTH unsigned coefficient
//   bypass     1      1 = pass din unscaled
//   sat_clr    1      clears sat_cnt
//   dout       WIDTH  signed scaled sample
//   dout_valid 1      output strobe
//   dout_ch    CHW    channel of dout
//   dout_sat   1      dout was clipped
//   sat_cnt    16     saturation event counter
`timescale 1ns/1ps
interface normmult_nch_if #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 16,
    parameter int NCH    = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic signed [WIDTH-1:0] din;
    logic                    din_valid;
    logic [CHW-1:0]          din_ch;
    logic                    coef_we;
    logic [CHW-1:0]          coef_addr;
    logic [CWIDTH-1:0]       coef_data;
    logic                    bypass;
    logic                    sat_clr;
    logic signed [WIDTH-1:0] dout;
    logic                    dout_valid;
    logic [CHW-1:0]          dout_ch;
    logic                    dout_sat;
    logic [15:0]             sat_cnt;

    modport master (
        output din, din_valid, din_ch, coef_we, coef_addr, coef_data, bypass, sat_clr,
        input  dout, dout_valid, dout_ch, dout_sat, sat_cnt
    );

    modport slave (
        input  din, din_valid, din_ch, coef_we, coef_addr, coef_data, bypass, sat_clr,
        output dout, dout_valid, dout_ch, dout_sat, sat_cnt
    );
endinterface

// File: rtl/normmult_nch.sv
// normmult_nch -- per-channel gain stage: dout = sat(round(din * coef[ch] / 2^FRAC)).
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   normmult_nch_if.slave (din/din_valid/din_ch, coef_we/coef_addr/coef_data,
//         bypass, sat_clr in; dout/dout_valid/dout_ch/dout_sat/sat_cnt out)
//
// A sample accepted at edge N is visible on dout with dout_valid=1 after edge N+3.
// Outputs hold their last values while dout_valid=0.
`timescale 1ns/1ps
module normmult_nch #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 16,
    parameter int FRAC   = 15,
    parameter int NCH    = 4
) (
    input logic           clk,
    input logic           rstn,
    normmult_nch_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = WIDTH + CWIDTH + 1;

    localparam logic [CWIDTH-1:0]    UNITY   = CWIDTH'(64'd1 << FRAC);
    localparam logic signed [PW-1:0] HALF    = PW'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(64'sd1 <<< (WIDTH - 1)));

    // Round half toward +infinity: add half an LSB, then arithmetic shift.
    function automatic logic signed [PW-1:0] round_frac(input logic signed [PW-1:0] p);
        round_frac = (p + HALF) >>> FRAC;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [WIDTH:0] saturate(input logic signed [PW-1:0] r);
        if (r > SAT_MAX) begin
            saturate = {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (r < SAT_MIN) begin
            saturate = {1'b1, SAT_MIN[WIDTH-1:0]};
        end else begin
            saturate = {1'b0, r[WIDTH-1:0]};
        end
    endfunction

    logic [CWIDTH-1:0] coef_q [NCH];
    logic              addr_ok;
    logic              ch_ok;
    logic [CWIDTH-1:0] coef_rd;

    assign addr_ok = ({1'b0, bus.coef_addr} < (CHW + 1)'(NCH));
    assign ch_ok   = ({1'b0, bus.din_ch} < (CHW + 1)'(NCH));
    assign coef_rd = ch_ok ? coef_q[bus.din_ch] : UNITY;

    // The table updates at the same edge the sample captures coef_rd, so a
    // colliding sample sees the old coefficient.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                coef_q[i] <= UNITY;
            end
        end else if (bus.coef_we && addr_ok) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    // ---- stage 1: sample, channel, coefficient, bypass flag ----
    logic                    vld_p1_q;
    logic signed [WIDTH-1:0] din_p1_q;
    logic [CHW-1:0]          ch_p1_q;
    logic [CWIDTH-1:0]       coef_p1_q;
    logic                    byp_p1_q;

    // ---- stage 2: full-precision product ----
    logic                    vld_p2_q;
    logic signed [PW-1:0]    prod_p2_q;
    logic [CHW-1:0]          ch_p2_q;
    logic signed [PW-1:0]    mul_a;
    logic signed [PW-1:0]    mul_b;
    logic signed [PW-1:0]    prod_d;

    // Bypass multiplies by unity, which rounds back to din exactly and can
    // never clip, keeping the latency identical to the scaled path.
    assign mul_a  = PW'(din_p1_q);
    assign mul_b  = signed'(PW'(byp_p1_q ? UNITY : coef_p1_q));
    assign prod_d = mul_a * mul_b;

    // ---- stage 3: rounded, saturated result ----
    logic                    vld_p3_q;
    logic signed [WIDTH-1:0] res_p3_q;
    logic                    sat_p3_q;
    logic [CHW-1:0]          ch_p3_q;
    logic [WIDTH:0]          sat_res_d;

    assign sat_res_d = saturate(round_frac(prod_p2_q));

    // ---- output register ----
    logic signed [WIDTH-1:0] dout_q;
    logic                    dout_valid_q;
    logic [CHW-1:0]          dout_ch_q;
    logic                    dout_sat_q;
    logic [15:0]             sat_cnt_q;
    logic [15:0]             sat_cnt_d;

    // Clear has priority over a coincident saturation event; count sticks at max.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (bus.sat_clr) begin
            sat_cnt_d = '0;
        end else if (vld_p3_q && sat_p3_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            vld_p3_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_sat_q   <= 1'b0;
            sat_cnt_q    <= '0;
        end else begin
            vld_p1_q     <= bus.din_valid;
            vld_p2_q     <= vld_p1_q;
            vld_p3_q     <= vld_p2_q;
            dout_valid_q <= vld_p3_q;
            sat_cnt_q    <= sat_cnt_d;
            if (vld_p3_q) begin
                dout_q     <= res_p3_q;
                dout_ch_q  <= ch_p3_q;
                dout_sat_q <= sat_p3_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.din_valid) begin
            din_p1_q  <= bus.din;
            ch_p1_q   <= bus.din_ch;
            coef_p1_q <= coef_rd;
            byp_p1_q  <= bus.bypass;
        end
        if (vld_p1_q) begin
            prod_p2_q <= prod_d;
            ch_p2_q   <= ch_p1_q;
        end
        if (vld_p2_q) begin
            res_p3_q <= signed'(sat_res_d[WIDTH-1:0]);
            sat_p3_q <= sat_res_d[WIDTH];
            ch_p3_q  <= ch_p2_q;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_sat   = dout_sat_q;
    assign bus.sat_cnt    = sat_cnt_q;
endmodule

// File: doc/normmult_nch.md
NORMMULT_NCH -- requirements
Module: normmult_nch

Interface
REQ-001 The parameter WIDTH SHALL default to 16 and set the signed sample width of din and dout.
REQ-002 The parameter CWIDTH SHALL default to 16 and set the unsigned coefficient width.
REQ-003 The parameter FRAC SHALL default to 15 and set the coefficient fractional bits, so that unity equals 2^FRAC.
REQ-004 The parameter NCH SHALL default to 4 and set the channel count; CHW = max(1, clog2(NCH)).
REQ-005 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port list, one per line as name  direction  width  meaning:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- din  in  WIDTH  signed input sample.
- din_valid  in  1  sample strobe.
- din_ch  in  CHW  channel of the sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  CHW  coefficient channel index.
- coef_data  in  CWIDTH  unsigned coefficient.
- bypass  in  1  1 = pass din unscaled.
- sat_clr  in  1  clears sat_cnt.
- dout  out  WIDTH  signed scaled sample.
- dout_valid  out  1  output strobe.
- dout_ch  out  CHW  channel of dout.
- dout_sat  out  1  dout was clipped.
- sat_cnt  out  16  saturation event counter.

Function
REQ-007 The block SHALL hold an NCH-entry coefficient table, written on rising clk when coef_we=1 and coef_addr<NCH.
REQ-008 Writes with coef_addr>=NCH SHALL be ignored.
REQ-009 A coefficient write SHALL take effect for samples accepted on the following cycle; a sample accepted in the same cycle as a write to its channel SHALL use the old coefficient.
REQ-010 Datapath: P = signed(din) * unsigned(coef[din_ch]) at WIDTH+CWIDTH+1 signed bits, with no overflow.
REQ-011 Rounding: R = (P + 2^(FRAC-1)) >>> FRAC, arithmetic shift, round half toward +infinity.
REQ-012 Saturation: R SHALL be clipped to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and dout_sat=1 SHALL mark any clipped sample.
REQ-013 When bypass=1 at acceptance, dout SHALL equal din, dout_sat=0, and latency SHALL be unchanged.
REQ-014 Pipeline: fixed 3-cycle latency; a sample accepted at edge N SHALL appear with dout_valid=1 after edge N+3.
REQ-015 Pipeline stages:
- stage 1 registers din, ch, and coef.
- stage 2 registers the product.
- stage 3 registers the rounded, saturated result.
REQ-016 The pipeline SHALL accept one sample per cycle with no backpressure; valid, ch, and the bypass flag SHALL travel with their sample.
REQ-017 When dout_valid=0, dout, dout_ch, and dout_sat SHALL hold their last values.
REQ-018 sat_cnt SHALL increment by 1 per valid output with dout_sat=1 and SHALL stick at 0xFFFF.
REQ-019 sat_clr=1 SHALL zero sat_cnt; if a saturation event coincides, the result SHALL be 0 because clear wins.

Reset
REQ-020 rstn=0 SHALL immediately set dout=0, dout_valid=0, dout_ch=0, dout_sat=0, sat_cnt=0, and clear all pipeline valid bits.
REQ-021 Reset SHALL load every coefficient entry with unity (2^FRAC, e.g. 0x8000).
REQ-022 Samples in flight when reset asserts SHALL be discarded and never emitted.
REQ-023 The first sample SHALL be accepted on the first rising clk after rstn deasserts.

Verification
REQ-024 Unity after reset: din=1000 on ch0 -> dout=1000 three cycles later, dout_ch=0, dout_sat=0.
REQ-025 Rounding: coef[1]=0x4000, with the write applied before the samples (REQ-009):
- din=3 on ch1 -> dout=2.
- din=-3 on ch1 -> dout=-1.
REQ-026 Saturation: coef[2]=0xFFFF:
- din=32767 -> dout=32767, dout_sat=1.
- din=-32768 -> dout=-32768, dout_sat=1.
- sat_cnt=2 after both.
REQ-027 Write/sample collision: coef_we on ch3 with 0x2000 in the same cycle as din=100 on ch3 -> dout=100; next sample din=100 -> dout=25.
REQ-028 Streaming and bypass:
- Back-to-back samples with din(n+1) = -2*din(n)+1 across all channels, bypass toggling -> outputs in order, exact 3-cycle latency, bypassed samples unchanged.
- rstn pulsed mid-stream -> no stale outputs.
